// File: rtl/word8_32bits_c_pkg.sv
// Shared definitions for the byte-to-word deserializer: lane indexing,
// lane bit offsets inside the 32-bit word and controller states.
`timescale 1ns/1ps
package word8_32bits_c_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;

  typedef logic [1:0] lane_idx_t;

  localparam lane_idx_t FIRST_LANE = 2'd0;
  localparam lane_idx_t LAST_LANE  = 2'(BYTES_PER_WORD - 1);

  // Stream is MSB-first, so lane 0 occupies the top byte of the word
  localparam logic [4:0] LANE0_LSB = 5'd24;
  localparam logic [4:0] LANE1_LSB = 5'd16;
  localparam logic [4:0] LANE2_LSB = 5'd8;
  localparam logic [4:0] LANE3_LSB = 5'd0;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } ctrl_state_t;

  function automatic logic [4:0] lane_lsb(input lane_idx_t idx);
    lane_lsb = LANE3_LSB;
    case (idx)
      2'd0:    lane_lsb = LANE0_LSB;
      2'd1:    lane_lsb = LANE1_LSB;
      2'd2:    lane_lsb = LANE2_LSB;
      default: lane_lsb = LANE3_LSB;
    endcase
  endfunction

endpackage

// File: rtl/word8_32bits_c_hold_timer.sv
// Presentation timer: keeps valid_out_c high for one clk_f period after
// each completed word, reloading seamlessly on back-to-back words.
`timescale 1ns/1ps
module word_hold_timer_c
  import word8_32bits_c_pkg::*;
(
  input  logic clk_4f_c,
  input  logic reset,
  input  logic load,
  output logic valid_out_c
);

  localparam logic [1:0] HOLD_RELOAD = 2'(BYTES_PER_WORD - 1);

  logic [1:0] hold_q;

  // The load edge itself is the first presentation cycle, hence reload of 3
  always_ff @(posedge clk_4f_c) begin
    if (reset) begin
      hold_q      <= 2'd0;
      valid_out_c <= 1'b0;
    end else if (load) begin
      hold_q      <= HOLD_RELOAD;
      valid_out_c <= 1'b1;
    end else if (hold_q != 2'd0) begin
      hold_q <= hold_q - 2'd1;
    end else begin
      valid_out_c <= 1'b0;
    end
  end

endmodule

// File: rtl/word8_32bits_c.sv
// Byte-to-word deserializer on the 4x clock: rebuilds MSB-first 32-bit words,
// flags bursts ending mid-word and counts completed words.
`timescale 1ns/1ps
module word8_32bits_c
  import word8_32bits_c_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_4f_c,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [7:0]       Data_in,
  output logic             valid_out_c,
  output logic [31:0]      Data_out_c,
  output logic             err_partial_c,
  output logic [CNT_W-1:0] word_cnt_c
);

  ctrl_state_t state_q, state_d;
  lane_idx_t   idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic        lane_we, clear_asm, complete, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lane_we   = 1'b0;
    clear_asm = 1'b0;
    complete  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          lane_we = 1'b1;
          idx_d   = FIRST_LANE + 2'd1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (valid_in) begin
          lane_we = 1'b1;
          if (idx_q == LAST_LANE) begin
            complete = 1'b1;
            idx_d    = FIRST_LANE;
            state_d  = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          // Burst dropped mid-word: discard the partial bytes
          err_d     = 1'b1;
          clear_asm = 1'b1;
          idx_d     = FIRST_LANE;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        idx_d   = FIRST_LANE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // The completing byte is merged combinationally so the word is registered
  // on the same edge that samples its last byte
  always_comb begin
    asm_d = asm_q;
    if (clear_asm) begin
      asm_d = '0;
    end else if (lane_we) begin
      asm_d[lane_lsb(idx_q) +: LANE_W] = Data_in;
    end
  end

  always_ff @(posedge clk_4f_c) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= FIRST_LANE;
      asm_q         <= '0;
      Data_out_c    <= '0;
      err_partial_c <= 1'b0;
      word_cnt_c    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      err_partial_c <= err_d;
      if (complete) begin
        asm_q      <= '0;
        Data_out_c <= asm_d;
        word_cnt_c <= word_cnt_c + CNT_W'(1);
      end else begin
        asm_q <= asm_d;
      end
    end
  end

  word_hold_timer_c u_hold_timer (
    .clk_4f_c    (clk_4f_c),
    .reset       (reset),
    .load        (complete),
    .valid_out_c (valid_out_c)
  );

endmodule

// File: tb/tb_word8_32bits_c.sv
// Self-checking bench for word8_32bits_c: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_word8_32bits_c;

  localparam int CNT_W = 8;

  logic             clk_4f_c = 1'b0;
  logic             reset    = 1'b1;
  logic             valid_in = 1'b0;
  logic [7:0]       Data_in  = 8'h00;
  logic             valid_out_c;
  logic [31:0]      Data_out_c;
  logic             err_partial_c;
  logic [CNT_W-1:0] word_cnt_c;

  int n_compared   = 0;
  int n_mismatched = 0;

  word8_32bits_c #(.CNT_W(CNT_W)) dut (
    .clk_4f_c      (clk_4f_c),
    .reset         (reset),
    .valid_in      (valid_in),
    .Data_in       (Data_in),
    .valid_out_c   (valid_out_c),
    .Data_out_c    (Data_out_c),
    .err_partial_c (err_partial_c),
    .word_cnt_c    (word_cnt_c)
  );

  always #5 clk_4f_c = ~clk_4f_c;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect bytes in a queue, emit a word on the 4th,
  // then present it for 4 edges counted from the completing edge
  logic [7:0]  byte_q[$];
  logic [31:0] exp_data;
  int          exp_left;
  logic        exp_err;
  int          exp_cnt;
  bit          model_ready = 1'b0;

  always @(posedge clk_4f_c) begin
    bit done;
    done = 1'b0;
    if (reset) begin
      byte_q.delete();
      exp_data    = 32'h0;
      exp_left    = 0;
      exp_err     = 1'b0;
      exp_cnt     = 0;
      model_ready = 1'b1;
    end else begin
      exp_err = 1'b0;
      if (valid_in) begin
        byte_q.push_back(Data_in);
        if (byte_q.size() == 4) begin
          exp_data = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
          byte_q.delete();
          exp_left = 4;
          exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
          done     = 1'b1;
        end
      end else if (byte_q.size() != 0) begin
        exp_err = 1'b1;
        byte_q.delete();
      end
      if (!done && exp_left > 0) exp_left--;
    end
  end

  always @(negedge clk_4f_c) begin
    if (model_ready) begin
      check_output("model valid_out_c", {31'b0, valid_out_c}, {31'b0, exp_left > 0});
      check_output("model err_partial_c", {31'b0, err_partial_c}, {31'b0, exp_err});
      check_output("model word_cnt_c", {{(32-CNT_W){1'b0}}, word_cnt_c}, 32'(exp_cnt));
      check_output("model Data_out_c", Data_out_c, exp_data);
    end
  end

  // Inputs change 1ns after an edge; outputs read after a call reflect the
  // previous call's inputs
  task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] b);
    @(posedge clk_4f_c);
    #1;
    reset    = r;
    valid_in = v;
    Data_in  = v ? b : 8'($urandom);
  endtask

  initial begin
    int hi;
    $display("[TB] start");
    apply_stimulus(1, 0, 8'h00);
    apply_stimulus(1, 0, 8'h00);

    // Reset mid-word, with a byte arriving on the reset edge
    apply_stimulus(0, 1, 8'hAA);
    apply_stimulus(0, 1, 8'hBB);
    apply_stimulus(1, 1, 8'hCC);
    apply_stimulus(0, 0, 8'h00);
    check_output("rst valid", {31'b0, valid_out_c}, 32'h0);
    check_output("rst data", Data_out_c, 32'h0);
    check_output("rst cnt", 32'(word_cnt_c), 32'h0);
    check_output("rst err", {31'b0, err_partial_c}, 32'h0);
    apply_stimulus(0, 1, 8'h01);
    apply_stimulus(0, 1, 8'h02);
    apply_stimulus(0, 1, 8'h03);
    apply_stimulus(0, 1, 8'h04);
    apply_stimulus(0, 0, 8'h00);
    check_output("first word", Data_out_c, 32'h01020304);
    check_output("first valid", {31'b0, valid_out_c}, 32'h1);
    check_output("first cnt", 32'(word_cnt_c), 32'd1);
    repeat (5) apply_stimulus(0, 0, 8'h00);

    // Continuous 12-byte burst
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(0, 1, 8'(i));
      if (i == 4) check_output("burst word0", Data_out_c, 32'h00010203);
      if (i == 8) check_output("burst word1", Data_out_c, 32'h04050607);
      if (i >= 4 && valid_out_c) hi++;
    end
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 8'h00);
      if (i == 0) check_output("burst word2", Data_out_c, 32'h08090A0B);
      if (valid_out_c) hi++;
    end
    check_output("burst valid cycles", 32'(hi), 32'd12);
    check_output("burst cnt", 32'(word_cnt_c), 32'd4);

    // Single word then idle: 4-cycle window, data retained
    apply_stimulus(0, 1, 8'hDE);
    apply_stimulus(0, 1, 8'hAD);
    apply_stimulus(0, 1, 8'hBE);
    apply_stimulus(0, 1, 8'hEF);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 8'h00);
      if (valid_out_c) hi++;
    end
    check_output("single valid cycles", 32'(hi), 32'd4);
    check_output("single valid low", {31'b0, valid_out_c}, 32'h0);
    check_output("single data kept", Data_out_c, 32'hDEADBEEF);

    // Partial word while idle
    apply_stimulus(0, 1, 8'h11);
    apply_stimulus(0, 1, 8'h22);
    apply_stimulus(0, 0, 8'h00);
    check_output("partial no err yet", {31'b0, err_partial_c}, 32'h0);
    apply_stimulus(0, 0, 8'h00);
    check_output("partial err", {31'b0, err_partial_c}, 32'h1);
    check_output("partial no valid", {31'b0, valid_out_c}, 32'h0);
    apply_stimulus(0, 1, 8'h55);
    check_output("partial err pulse", {31'b0, err_partial_c}, 32'h0);
    check_output("partial cnt", 32'(word_cnt_c), 32'd5);
    apply_stimulus(0, 1, 8'h66);
    apply_stimulus(0, 1, 8'h77);
    apply_stimulus(0, 1, 8'h88);
    apply_stimulus(0, 0, 8'h00);
    check_output("after partial word", Data_out_c, 32'h55667788);
    repeat (5) apply_stimulus(0, 0, 8'h00);

    // Partial word inside a hold window
    apply_stimulus(0, 1, 8'hCA);
    apply_stimulus(0, 1, 8'hFE);
    apply_stimulus(0, 1, 8'hF0);
    apply_stimulus(0, 1, 8'h0D);
    apply_stimulus(0, 1, 8'h01);
    apply_stimulus(0, 1, 8'h02);
    apply_stimulus(0, 0, 8'h00);
    apply_stimulus(0, 0, 8'h00);
    check_output("hold err", {31'b0, err_partial_c}, 32'h1);
    check_output("hold valid 4th", {31'b0, valid_out_c}, 32'h1);
    check_output("hold data", Data_out_c, 32'hCAFEF00D);
    apply_stimulus(0, 0, 8'h00);
    check_output("hold valid end", {31'b0, valid_out_c}, 32'h0);
    check_output("hold cnt", 32'(word_cnt_c), 32'd7);

    // Counter wrap after 256 words from reset
    apply_stimulus(1, 0, 8'h00);
    for (int w = 0; w < 256; w++)
      for (int k = 0; k < 4; k++)
        apply_stimulus(0, 1, 8'(w * 4 + k));
    apply_stimulus(0, 0, 8'h00);
    check_output("wrap cnt", 32'(word_cnt_c), 32'h0);
    check_output("wrap last word", Data_out_c, 32'hFCFDFEFF);
    check_output("wrap valid", {31'b0, valid_out_c}, 32'h1);
    repeat (6) apply_stimulus(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/word8_32bits_c.md
Name: word8_32bits_c

Overview:
- Byte-to-word deserializer on the 4x clock domain.
- Sits directly downstream of the 32b-to-8b serializer and rebuilds 32-bit words from its MSB-first byte stream.
- Presents each rebuilt word held stable for one clk_f period (4 clk_4f_c cycles), ready for the clk_f-domain consumer.
- Flags bursts that end on a partial word and counts completed words for debug.

Parameters:
CNT_W, 8, width of the completed-word counter (wraps modulo 2^CNT_W)

Ports:
clk_4f_c  input  1  4x clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset, sampled on rising clk_4f_c
valid_in  input  1  byte on Data_in is valid this cycle
Data_in  input  8  input byte; first byte of each word is bits [31:24]
valid_out_c  output  1  Data_out_c holds a complete word
Data_out_c  output  32  reassembled word
err_partial_c  output  1  one-cycle pulse: burst ended mid-word, partial bytes discarded
word_cnt_c  output  CNT_W  number of completed words since reset

Behaviour:
- Reset: valid_out_c=0, Data_out_c=32'h0, err_partial_c=0, word_cnt_c=0, byte index=0, hold counter=0, assembly register=0. Reset wins over every other event in the same cycle, including a byte arriving mid-word.
- Byte index idx (2 bits) selects the assembly lane: 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0].
- Edge with valid_in=1 and idx<3: write Data_in into the lane; idx<=idx+1.
- Edge with valid_in=1 and idx=3 (word completion), all registered at that same edge:
  - Data_out_c <= {lanes 0..2, Data_in}.
  - valid_out_c <= 1.
  - hold <= 3.
  - idx <= 0.
  - word_cnt_c <= word_cnt_c+1, wrapping at 2^CNT_W.
- Latency: the 4th byte is sampled at edge N; the word is visible on Data_out_c right after edge N.
- Hold window:
  - While hold>0 and no new completion: hold decrements each edge; Data_out_c and valid_out_c are unchanged.
  - At the edge where hold is 0 and no completion occurs: valid_out_c<=0.
  - Data_out_c keeps the last word; it is not cleared.
- Continuous stream (valid_in high for 4k cycles): the next completion reloads hold exactly as the window expires. valid_out_c stays high without a gap, and Data_out_c changes every 4 cycles.
- valid_in=0 with idx=0: idle; no error, idx unchanged.
- valid_in=0 with idx!=0 (partial word):
  - err_partial_c<=1 for exactly one cycle.
  - idx<=0 and the assembly register is cleared.
  - The hold window in progress is unaffected, so the previous word still completes its 4-cycle presentation.
- err_partial_c is 0 in every other cycle.
- valid_in re-asserted immediately after an error: the byte is taken as lane 0 of a new word.
- Data_in is a don't-care whenever valid_in=0.
- Controller states:
  - IDLE (idx=0, no partial data).
  - COLLECT (idx 1..3).
  - The hold counter is an independent counter, not an FSM state.

Decomposition:
- Shared package holds:
  - BYTES_PER_WORD=4.
  - Lane-index typedef (2-bit).
  - Lane bit-offset constants.
- Sub-module word_hold_timer_c (hold counter plus valid_out_c generation, load/decrement interface) is natural.
- Byte assembly and idx logic live in the top module.

Test Plan:
- Reset asserted mid-word (after bytes AA,BB): all outputs 0 at the next edge. Bytes 01,02,03,04 after release -> Data_out_c=32'h01020304, valid_out_c=1 right after the 4th byte's edge, word_cnt_c=1.
- Continuous 12-cycle burst 00..0B -> words 32'h00010203, 32'h04050607, 32'h08090A0B, each held 4 cycles. valid_out_c high continuously for 12 cycles, then low. word_cnt_c=3.
- Bytes DE,AD,BE,EF, then valid_in low 5 cycles -> valid_out_c high exactly 4 cycles. Data_out_c stays 32'hDEADBEEF after valid_out_c drops.
- Partial word: bytes 11,22 then valid_in low -> err_partial_c single-cycle pulse, no valid_out_c, word_cnt_c unchanged. Next 4 bytes 55,66,77,88 -> 32'h55667788.
- Partial word during a hold window: word 32'hCAFEF00D completes, then bytes 01,02 and a drop -> error pulse, and valid_out_c still lasts the full 4 cycles with 32'hCAFEF00D.
- Counter wrap: 256 complete words with CNT_W=8 -> word_cnt_c returns to 0, no other side effects.
